// File: rtl/traffic_pkg.sv
// Shared types and timing defaults for the traffic-light controller
// and its input conditioning logic.
package traffic_pkg;

  localparam int CLK_HZ      = 1000000;
  localparam int DEBOUNCE_MS = 1;
  localparam int STUCK_S     = 2;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARM     = 3'd1,
    ST_PRESENT = 3'd2,
    ST_REL     = 3'd3,
    ST_FAULT   = 3'd4
  } cond_state_e;

  function automatic int ms_to_cycles(input int ms);
    return (CLK_HZ / 1000) * ms;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous external inputs.
// Asynchronous active-high reset clears both stages.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/sensor_conditioner.sv
// Vehicle-loop conditioner: sync, debounce, arrival pulse,
// saturating vehicle counter and stuck-loop fault flag.
module sensor_conditioner
  import traffic_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = ms_to_cycles(DEBOUNCE_MS),
  parameter int STUCK_CYCLES    = CLK_HZ * STUCK_S,
  parameter int CNT_W           = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             raw_loop,
  input  logic             clr_count,
  output logic             sensor,
  output logic             arrive,
  output logic [CNT_W-1:0] vehicle_count,
  output logic             fault
);

  localparam int TW = $clog2(STUCK_CYCLES);
  localparam logic [TW-1:0] DEB_END = TW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] STK_END = TW'(STUCK_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  cond_state_e      state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d, timer_inc;
  logic [CNT_W-1:0] count_base, count_d;
  logic             sensor_d, arrive_d, fault_d;
  logic             sync;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (raw_loop),
    .q   (sync)
  );

  assign timer_inc  = timer_q + 1'b1;
  // A clear on the arrival edge wins first, so the arrival lands on 0.
  assign count_base = clr_count ? '0 : vehicle_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      timer_q       <= '0;
      sensor        <= 1'b0;
      arrive        <= 1'b0;
      fault         <= 1'b0;
      vehicle_count <= '0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      sensor        <= sensor_d;
      arrive        <= arrive_d;
      fault         <= fault_d;
      vehicle_count <= count_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    sensor_d = sensor;
    fault_d  = fault;
    arrive_d = 1'b0;
    count_d  = count_base;
    unique case (state_q)
      ST_IDLE: begin
        sensor_d = 1'b0;
        fault_d  = 1'b0;
        if (sync) begin
          state_d = ST_ARM;
          timer_d = '0;
        end
      end
      ST_ARM: begin
        sensor_d = 1'b0;
        if (!sync) begin
          state_d = ST_IDLE;
          timer_d = '0;
        end else if (timer_q == DEB_END) begin
          state_d  = ST_PRESENT;
          timer_d  = '0;
          sensor_d = 1'b1;
          arrive_d = 1'b1;
          if (count_base != CNT_MAX)
            count_d = count_base + 1'b1;
        end else begin
          timer_d = timer_inc;
        end
      end
      ST_PRESENT: begin
        sensor_d = 1'b1;
        if (!sync) begin
          state_d = ST_REL;
          timer_d = '0;
        end else if (timer_q == STK_END) begin
          state_d = ST_FAULT;
          timer_d = '0;
          fault_d = 1'b1;
        end else begin
          timer_d = timer_inc;
        end
      end
      ST_REL: begin
        sensor_d = 1'b1;
        if (sync) begin
          state_d = ST_PRESENT;
          timer_d = '0;
        end else if (timer_q == DEB_END) begin
          state_d  = ST_IDLE;
          timer_d  = '0;
          sensor_d = 1'b0;
        end else begin
          timer_d = timer_inc;
        end
      end
      ST_FAULT: begin
        // Keep serving the farm road until the loop clearly releases.
        sensor_d = 1'b1;
        fault_d  = 1'b1;
        if (sync) begin
          timer_d = '0;
        end else if (timer_q == DEB_END) begin
          state_d  = ST_IDLE;
          timer_d  = '0;
          sensor_d = 1'b0;
          fault_d  = 1'b0;
        end else begin
          timer_d = timer_inc;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        timer_d  = '0;
        sensor_d = 1'b0;
        fault_d  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_sensor_conditioner.sv
// Scoreboard bench for sensor_conditioner with short debounce/stuck
// timings; expected output events are queued by the stimulus process.
module tb_sensor_conditioner;

  localparam int DEB = 4;
  localparam int STK = 20;
  localparam int CW  = 4;

  typedef enum int {EV_ARR, EV_RISE, EV_FALL, EV_FON, EV_FOFF} ev_e;

  typedef struct {
    ev_e         kind;
    int          cyc;
    logic [CW-1:0] cnt;
  } ev_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          raw_loop = 1'b0;
  logic          clr_count = 1'b0;
  logic          sensor;
  logic          arrive;
  logic [CW-1:0] vehicle_count;
  logic          fault;

  int  cyc = 0;
  int  n_checks = 0;
  int  n_fail = 0;
  ev_t exp_q[$];
  logic p_sensor = 1'b0;
  logic p_fault = 1'b0;

  sensor_conditioner #(
    .DEBOUNCE_CYCLES (DEB),
    .STUCK_CYCLES    (STK),
    .CNT_W           (CW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .raw_loop      (raw_loop),
    .clr_count     (clr_count),
    .sensor        (sensor),
    .arrive        (arrive),
    .vehicle_count (vehicle_count),
    .fault         (fault)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  task automatic push(input ev_e k, input int c, input int n);
    ev_t e;
    e.kind = k;
    e.cyc  = c;
    e.cnt  = CW'(n);
    exp_q.push_back(e);
  endtask

  task automatic got(input ev_e k);
    ev_t e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_event: got %s at cycle %0d count %0d, required none",
               k.name(), cyc, vehicle_count);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.cyc != cyc ||
          (k == EV_ARR && e.cnt != vehicle_count)) begin
        n_fail++;
        $display("FAIL event: got %s cyc %0d cnt %0d, required %s cyc %0d cnt %0d",
                 k.name(), cyc, vehicle_count, e.kind.name(), e.cyc, e.cnt);
      end
    end
  endtask

  always @(negedge clk) begin
    if (arrive) got(EV_ARR);
    if (sensor && !p_sensor) got(EV_RISE);
    if (!sensor && p_sensor) got(EV_FALL);
    if (fault && !p_fault) got(EV_FON);
    if (!fault && p_fault) got(EV_FOFF);
    p_sensor = sensor;
    p_fault  = fault;
  end

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    step(1);
  endtask

  initial begin
    int k;
    step(3);
    rst = 1'b0;
    step(1);

    // clean arrival then release
    k = cyc;
    raw_loop = 1'b1;
    push(EV_ARR, k + 7, 1);
    push(EV_RISE, k + 7, 1);
    step(12);
    raw_loop = 1'b0;
    push(EV_FALL, cyc + 7, 0);
    step(10);
    chk("count_after_clean", vehicle_count, 1);

    // async reset in the middle of ARM
    raw_loop = 1'b1;
    step(4);
    #2 rst = 1'b1;
    #1;
    chk("rst_sensor", sensor, 0);
    chk("rst_arrive", arrive, 0);
    chk("rst_count", vehicle_count, 0);
    chk("rst_fault", fault, 0);
    @(negedge clk);
    step(1);
    rst = 1'b0;
    k = cyc;
    push(EV_ARR, k + 7, 1);
    push(EV_RISE, k + 7, 1);
    step(10);
    raw_loop = 1'b0;
    push(EV_FALL, cyc + 7, 0);
    step(10);

    // glitch rejection
    do_reset();
    for (int w = 1; w <= 3; w++) begin
      raw_loop = 1'b1;
      step(w);
      raw_loop = 1'b0;
      step(6);
    end
    chk("glitch_count", vehicle_count, 0);
    chk("glitch_sensor", sensor, 0);
    k = cyc;
    raw_loop = 1'b1;
    push(EV_ARR, k + 7, 1);
    push(EV_RISE, k + 7, 1);
    step(12);
    raw_loop = 1'b0;
    step(3);
    raw_loop = 1'b1;
    step(9);
    raw_loop = 1'b0;
    push(EV_FALL, cyc + 7, 0);
    step(10);
    chk("dropout_count", vehicle_count, 1);

    // stuck loop
    do_reset();
    k = cyc;
    raw_loop = 1'b1;
    push(EV_ARR, k + 7, 1);
    push(EV_RISE, k + 7, 1);
    push(EV_FON, k + 7 + STK, 1);
    step(40);
    chk("stuck_sensor", sensor, 1);
    raw_loop = 1'b0;
    push(EV_FALL, cyc + 6, 0);
    push(EV_FOFF, cyc + 6, 0);
    step(10);
    chk("stuck_count", vehicle_count, 1);
    chk("stuck_fault_clear", fault, 0);

    // saturation and clear
    do_reset();
    for (int i = 1; i <= 17; i++) begin
      k = cyc;
      raw_loop = 1'b1;
      push(EV_ARR, k + 7, (i > 15) ? 15 : i);
      push(EV_RISE, k + 7, 0);
      step(8);
      raw_loop = 1'b0;
      push(EV_FALL, k + 15, 0);
      step(8);
    end
    chk("sat_count", vehicle_count, 15);
    k = cyc;
    raw_loop = 1'b1;
    push(EV_ARR, k + 7, 1);
    push(EV_RISE, k + 7, 0);
    step(6);
    clr_count = 1'b1;
    step(1);
    clr_count = 1'b0;
    step(1);
    raw_loop = 1'b0;
    push(EV_FALL, k + 15, 0);
    step(8);
    chk("clr_with_arrival", vehicle_count, 1);
    clr_count = 1'b1;
    step(1);
    clr_count = 1'b0;
    step(1);
    chk("clr_alone", vehicle_count, 0);

    // back-to-back vehicles
    do_reset();
    k = cyc;
    raw_loop = 1'b1;
    push(EV_ARR, k + 7, 1);
    push(EV_RISE, k + 7, 0);
    step(8);
    raw_loop = 1'b0;
    push(EV_FALL, k + 15, 0);
    step(8);
    raw_loop = 1'b1;
    push(EV_ARR, k + 23, 2);
    push(EV_RISE, k + 23, 0);
    step(8);
    raw_loop = 1'b0;
    push(EV_FALL, k + 31, 0);
    step(10);
    chk("b2b_count", vehicle_count, 2);

    step(5);
    while (exp_q.size() > 0) begin
      ev_t e;
      e = exp_q.pop_front();
      n_checks++;
      n_fail++;
      $display("FAIL missing_event: got nothing, required %s at cycle %0d",
               e.kind.name(), e.cyc);
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
